// File: rtl/imem_line_buffer_if.sv
// Fetch-side and memory-side buses of the instruction line buffer.
// The slave modport is the buffer's view; master is the surrounding environment.
interface imem_line_buffer_if;
  logic [15:0]  imem_address;
  logic         imem_action_cyc;
  logic         imem_action_stb;
  logic [127:0] imem_rdata;
  logic         imem_resp;
  logic         invalidate;
  logic [15:0]  pmem_address;
  logic         pmem_cyc;
  logic         pmem_stb;
  logic         pmem_ack;
  logic [127:0] pmem_rdata;

  modport slave (
    input  imem_address, imem_action_cyc, imem_action_stb, invalidate,
    input  pmem_ack, pmem_rdata,
    output imem_rdata, imem_resp, pmem_address, pmem_cyc, pmem_stb
  );

  modport master (
    output imem_address, imem_action_cyc, imem_action_stb, invalidate,
    output pmem_ack, pmem_rdata,
    input  imem_rdata, imem_resp, pmem_address, pmem_cyc, pmem_stb
  );
endinterface

// File: rtl/imem_line_buffer.sv
// Two-entry direct-mapped 128-bit instruction line buffer with a single
// outstanding line fill; hits are answered combinationally in IDLE.
//
// state | meaning
// IDLE  | serve hits, latch miss address on a miss
// FILL  | memory request held until pmem_ack, line written on ack
// DONE  | one bubble cycle before serving requests again
module imem_line_buffer (
  input logic               clk,
  input logic               rst,
  imem_line_buffer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  state_t       state;
  state_t       state_nxt;
  logic [1:0]   valid;
  logic [10:0]  tag_mem  [2];
  logic [127:0] data_mem [2];
  logic [11:0]  miss_addr;

  logic         idx;
  logic [10:0]  req_tag;
  logic         req;
  logic         hit_raw;
  logic         miss;
  logic         fill_done;
  logic         unused_offset;

  assign idx           = bus.imem_address[4];
  assign req_tag       = bus.imem_address[15:5];
  assign unused_offset = ^bus.imem_address[3:0];
  assign req           = bus.imem_action_cyc & bus.imem_action_stb;

  assign hit_raw   = req & valid[idx] & (tag_mem[idx] == req_tag) & (state == IDLE);
  assign miss      = req & ~hit_raw & (state == IDLE);
  assign fill_done = (state == FILL) & bus.pmem_ack;

  // A valid line that is being invalidated this cycle is not reported as a hit.
  assign bus.imem_resp    = hit_raw & ~bus.invalidate & ~rst;
  assign bus.imem_rdata   = data_mem[idx];
  assign bus.pmem_address = {miss_addr, 4'b0000};

  always_comb begin
    state_nxt    = state;
    bus.pmem_cyc = 1'b0;
    bus.pmem_stb = 1'b0;
    case (state)
      IDLE: begin
        if (miss) state_nxt = FILL;
      end
      FILL: begin
        bus.pmem_cyc = ~rst;
        bus.pmem_stb = ~rst;
        if (bus.pmem_ack) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      valid     <= 2'b00;
      miss_addr <= 12'h000;
    end else begin
      state <= state_nxt;
      if (miss) miss_addr <= bus.imem_address[15:4];
      if (bus.invalidate) valid <= 2'b00;
      // An invalidate racing the fill discards the incoming line.
      if (fill_done) valid[miss_addr[0]] <= ~bus.invalidate;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && fill_done) begin
      tag_mem[miss_addr[0]]  <= miss_addr[11:1];
      data_mem[miss_addr[0]] <= bus.pmem_rdata;
    end
  end
endmodule

// File: tb/tb_imem_line_buffer.sv
// Directed cycle-by-cycle vectors for the line buffer plus a bounded
// miss-latency sequence with a stalled memory.
module tb_imem_line_buffer;
  logic clk;
  logic rst;

  imem_line_buffer_if bus ();

  imem_line_buffer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         rst;
    logic         cyc;
    logic         stb;
    logic [15:0]  addr;
    logic         inval;
    logic         ack;
    logic [127:0] pdata;
    logic         exp_resp;
    logic         exp_pcyc;
    logic [15:0]  exp_paddr;
    logic [127:0] exp_rdata;
  } vec_t;

  localparam logic [127:0] LA = {4{32'hAAAA_0001}};
  localparam logic [127:0] LB = {4{32'hBBBB_0002}};
  localparam logic [127:0] LC = {4{32'hCCCC_0003}};
  localparam logic [127:0] LD = {4{32'hDDDD_0004}};
  localparam logic [127:0] LE = {4{32'hEEEE_0005}};
  localparam logic [127:0] LF = {4{32'hF0F0_0006}};
  localparam logic [127:0] LX = {4{32'h5A5A_0007}};

  vec_t vq[$];
  int   errors = 0;
  int   checks = 0;

  task automatic row(input logic r, input logic c, input logic s, input logic [15:0] a,
                     input logic inv, input logic ak, input logic [127:0] pd,
                     input logic er, input logic ep, input logic [15:0] epa,
                     input logic [127:0] erd);
    vec_t v;
    v.rst = r; v.cyc = c; v.stb = s; v.addr = a; v.inval = inv; v.ack = ak;
    v.pdata = pd; v.exp_resp = er; v.exp_pcyc = ep; v.exp_paddr = epa; v.exp_rdata = erd;
    vq.push_back(v);
  endtask

  task automatic check1(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    int resp_cycle;
    int stalls;

    rst = 1'b1;
    bus.imem_address = 16'h0; bus.imem_action_cyc = 1'b0; bus.imem_action_stb = 1'b0;
    bus.invalidate = 1'b0; bus.pmem_ack = 1'b0; bus.pmem_rdata = '0;

    //   rst cyc stb addr     inv ack pdata resp pcyc paddr    rdata
    row(1, 1, 1, 16'h1234, 0, 0, LX, 0, 0, 16'h0000, LX); // reset
    row(0, 1, 1, 16'h1234, 0, 0, LX, 0, 0, 16'h0000, LX); // cold miss, cycle 0
    row(0, 1, 1, 16'h1234, 0, 0, LX, 0, 1, 16'h1230, LX);
    row(0, 1, 1, 16'h1234, 0, 0, LX, 0, 1, 16'h1230, LX);
    row(0, 1, 1, 16'h1234, 0, 1, LA, 0, 1, 16'h1230, LX);
    row(0, 1, 1, 16'h1234, 0, 0, LX, 0, 0, 16'h0000, LX); // DONE bubble
    row(0, 1, 1, 16'h1234, 0, 0, LX, 1, 0, 16'h0000, LA); // hit at cycle 5
    row(0, 1, 1, 16'h1240, 0, 0, LX, 0, 0, 16'h0000, LX); // miss index 0
    row(0, 1, 1, 16'h1240, 0, 1, LB, 0, 1, 16'h1240, LX);
    row(0, 1, 1, 16'h1240, 0, 0, LX, 0, 0, 16'h0000, LX);
    row(0, 1, 1, 16'h1240, 0, 0, LX, 1, 0, 16'h0000, LB);
    row(0, 1, 1, 16'h123C, 0, 0, LX, 1, 0, 16'h0000, LA); // alternate hits
    row(0, 1, 1, 16'h1244, 0, 0, LX, 1, 0, 16'h0000, LB);
    row(0, 1, 1, 16'h1230, 0, 0, LX, 1, 0, 16'h0000, LA);
    row(0, 1, 1, 16'h2230, 0, 0, LX, 0, 0, 16'h0000, LX); // conflict miss
    row(0, 1, 1, 16'h2230, 0, 1, LC, 0, 1, 16'h2230, LX);
    row(0, 1, 1, 16'h2230, 0, 0, LX, 0, 0, 16'h0000, LX);
    row(0, 1, 1, 16'h2230, 0, 0, LX, 1, 0, 16'h0000, LC);
    row(0, 1, 1, 16'h1240, 0, 0, LX, 1, 0, 16'h0000, LB); // other entry intact
    row(0, 1, 1, 16'h1230, 0, 0, LX, 0, 0, 16'h0000, LX); // evicted line misses
    row(0, 1, 1, 16'h4000, 0, 0, LX, 0, 1, 16'h1230, LX); // redirect in FILL
    row(0, 1, 0, 16'h4000, 0, 1, LD, 0, 1, 16'h1230, LX); // strobe dropped, ack
    row(0, 1, 1, 16'h4000, 0, 0, LX, 0, 0, 16'h0000, LX);
    row(0, 1, 1, 16'h4000, 0, 0, LX, 0, 0, 16'h0000, LX); // new miss in IDLE
    row(0, 1, 1, 16'h4000, 0, 1, LE, 0, 1, 16'h4000, LX);
    row(0, 1, 1, 16'h1230, 0, 0, LX, 0, 0, 16'h0000, LX);
    row(0, 1, 1, 16'h1230, 0, 0, LX, 1, 0, 16'h0000, LD); // redirected fill kept
    row(0, 1, 1, 16'h4000, 0, 0, LX, 1, 0, 16'h0000, LE);
    row(0, 1, 1, 16'h2230, 0, 0, LX, 0, 0, 16'h0000, LX);
    row(0, 1, 1, 16'h2230, 1, 1, LC, 0, 1, 16'h2230, LX); // invalidate with ack
    row(0, 1, 1, 16'h2230, 0, 0, LX, 0, 0, 16'h0000, LX);
    row(0, 1, 1, 16'h2230, 0, 0, LX, 0, 0, 16'h0000, LX); // misses again
    row(0, 1, 1, 16'h2230, 0, 1, LC, 0, 1, 16'h2230, LX);
    row(0, 1, 1, 16'h2230, 0, 0, LX, 0, 0, 16'h0000, LX);
    row(0, 1, 1, 16'h2230, 0, 0, LX, 1, 0, 16'h0000, LC);
    row(0, 1, 1, 16'h2230, 1, 0, LX, 0, 0, 16'h0000, LX); // invalidate in IDLE
    row(0, 1, 1, 16'h2230, 0, 0, LX, 0, 0, 16'h0000, LX);
    row(1, 1, 1, 16'h2230, 0, 1, LA, 0, 0, 16'h0000, LX); // rst + ack in FILL
    row(0, 1, 1, 16'h2230, 0, 0, LX, 0, 0, 16'h0000, LX);
    row(0, 1, 1, 16'h2230, 0, 0, LX, 0, 1, 16'h2230, LX);
    row(0, 0, 0, 16'h2230, 0, 1, LC, 0, 1, 16'h2230, LX);
    row(0, 1, 1, 16'h2230, 0, 0, LX, 0, 0, 16'h0000, LX);
    row(0, 1, 1, 16'h2230, 0, 0, LX, 1, 0, 16'h0000, LC);

    foreach (vq[i]) begin
      @(negedge clk);
      rst = vq[i].rst;
      bus.imem_action_cyc = vq[i].cyc; bus.imem_action_stb = vq[i].stb;
      bus.imem_address = vq[i].addr; bus.invalidate = vq[i].inval;
      bus.pmem_ack = vq[i].ack; bus.pmem_rdata = vq[i].pdata;
      #2;
      check1($sformatf("v%0d imem_resp", i), {127'b0, bus.imem_resp}, {127'b0, vq[i].exp_resp});
      check1($sformatf("v%0d pmem_cyc", i), {127'b0, bus.pmem_cyc}, {127'b0, vq[i].exp_pcyc});
      check1($sformatf("v%0d pmem_stb", i), {127'b0, bus.pmem_stb}, {127'b0, vq[i].exp_pcyc});
      if (vq[i].exp_pcyc)
        check1($sformatf("v%0d pmem_address", i), {112'b0, bus.pmem_address}, {112'b0, vq[i].exp_paddr});
      if (vq[i].exp_resp)
        check1($sformatf("v%0d imem_rdata", i), bus.imem_rdata, vq[i].exp_rdata);
    end

    // Miss with three stalled FILL cycles: response expected at cycle N+3 = 6.
    @(negedge clk);
    rst = 1'b0; bus.invalidate = 1'b0; bus.pmem_ack = 1'b0; bus.pmem_rdata = LF;
    bus.imem_action_cyc = 1'b1; bus.imem_action_stb = 1'b1; bus.imem_address = 16'h8010;
    #2;
    check1("lat resp at cycle 0", {127'b0, bus.imem_resp}, 128'd0);
    resp_cycle = -1;
    stalls = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      bus.pmem_ack = 1'b0;
      #1;
      if (bus.pmem_stb) begin
        if (stalls == 3) bus.pmem_ack = 1'b1;
        else stalls++;
      end
      #1;
      if (bus.imem_resp && resp_cycle < 0) resp_cycle = c;
    end
    check1("lat stall count", 128'(stalls), 128'd3);
    check1("lat resp cycle", 128'(resp_cycle), 128'd6);
    check1("lat rdata", bus.imem_rdata, LF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
